parity_gen: RTL

- Transmit-side data-integrity stage: accepts a valid/ready data stream, computes one parity bit per beat, and forwards data plus parity downstream.
- Parity is even by default, odd by parameter; a downstream receiver checks it.
- Contains a 2-entry skid buffer, so throughput is one beat per cycle and rdy_o is registered.
- One-shot parity-error injection lets benches and in-system tests exercise downstream checkers.

---
 rtl/parity_pkg.sv | 5 +
 rtl/skid_buf.sv | 51 +++++
 rtl/parity_gen.sv | 65 ++++++
 3 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared parity-sense constants for the parity generator slice.
package parity_pkg;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
endpackage

// File: rtl/skid_buf.sv
// skid_buf: two-entry valid/ready buffer (output register plus skid register)
// giving full throughput with a registered upstream ready.
module skid_buf
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  vld_i,
    output logic                  rdy_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  vld_o,
    input  logic                  rdy_i,
    output logic [DATA_WIDTH-1:0] dat_o
);
    logic                  r_vld, r_rdy, r_skid_vld;
    logic [DATA_WIDTH-1:0] r_dat, r_skid;
    logic                  w_acc, w_load, w_skid_nxt;

    assign w_acc      = vld_i & r_rdy;
    assign w_load     = ~r_vld | rdy_i;
    // The skid only fills when the output register is stuck; any load drains it.
    assign w_skid_nxt = ~w_load & (r_skid_vld | w_acc);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_vld      <= 1'b0;
            r_rdy      <= 1'b1;
            r_skid_vld <= 1'b0;
            r_dat      <= '0;
            r_skid     <= '0;
        end else begin
            if (w_load) begin
                r_vld <= r_skid_vld | w_acc;
                if (r_skid_vld)
                    r_dat <= r_skid;
                else if (w_acc)
                    r_dat <= dat_i;
            end
            if (!w_load && w_acc)
                r_skid <= dat_i;
            r_skid_vld <= w_skid_nxt;
            r_rdy      <= ~w_skid_nxt;
        end
    end

    assign rdy_o = r_rdy;
    assign vld_o = r_vld;
    assign dat_o = r_dat;
endmodule

// File: rtl/parity_gen.sv
// parity_gen: appends a parity bit to each accepted beat and forwards it through
// a skid buffer; supports one-shot parity corruption with a saturating count.
module parity_gen
    import parity_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter logic PARITY_ODD = PARITY_EVEN,
    parameter int   CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  vld_i,
    output logic                  rdy_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  vld_o,
    input  logic                  rdy_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  par_o,
    input  logic                  inj_arm_i,
    output logic                  inj_pend_o,
    output logic [CNT_WIDTH-1:0]  inj_cnt_o
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  par;
    } beat_t;

    beat_t                w_in, w_out;
    logic                 w_acc, w_inj;
    logic                 r_pend;
    logic [CNT_WIDTH-1:0] r_cnt;

    assign w_acc      = vld_i & rdy_o;
    assign w_inj      = w_acc & r_pend;
    assign w_in.data  = dat_i;
    assign w_in.par   = ^dat_i ^ PARITY_ODD ^ w_inj;

    skid_buf #(.DATA_WIDTH($bits(beat_t))) u_buf (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .vld_i   (vld_i),
        .rdy_o   (rdy_o),
        .dat_i   (w_in),
        .vld_o   (vld_o),
        .rdy_i   (rdy_i),
        .dat_o   (w_out)
    );

    // An arm arriving with the injecting beat re-arms for the following beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pend <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_pend <= w_inj ? inj_arm_i : (r_pend | inj_arm_i);
            if (w_inj && r_cnt != '1)
                r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign dat_o      = w_out.data;
    assign par_o      = w_out.par;
    assign inj_pend_o = r_pend;
    assign inj_cnt_o  = r_cnt;
endmodule
